// File: rtl/spi_tx_fifo.sv
// Show-ahead transmit FIFO between the SPI register block and the shift core.
// Optional macro SPI_TXFIFO_THRESH_EN adds thresh_in / below_thresh_out.
module spi_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  apb_clk_in,
    input  logic                  apb_rst_in,
    input  logic                  flush_in,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  overflow_out,
    output logic                  underflow_out,
`ifdef SPI_TXFIFO_THRESH_EN
    input  logic [CNT_WIDTH-1:0]  thresh_in,
    output logic                  below_thresh_out,
`endif
    input  logic                  err_clr_in
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  is_full, is_empty;
    logic                  do_push, do_pop, mem_we;

    assign is_full  = (level_q == CNT_WIDTH'(FIFO_DEPTH));
    assign is_empty = (level_q == '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        mem_we  = 1'b0;
        // A pop while full frees the slot the coincident push lands in.
        do_push = wr_en_in && (!is_full || rd_en_in);
        do_pop  = rd_en_in && !is_empty;

        if (flush_in) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            // An error event in the clear cycle wins, so the flag ends set.
            ovf_d = (ovf_q && !err_clr_in) || (wr_en_in && is_full && !rd_en_in);
            udf_d = (udf_q && !err_clr_in) || (rd_en_in && is_empty);
            if (do_push) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + CNT_WIDTH'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; only pointers and level define validity.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge apb_clk_in) begin
            if (mem_we && (wptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= wr_data_in;
            end
        end
    end

    assign rd_data_out   = mem_q[rptr_q];
    assign empty_out     = is_empty;
    assign full_out      = is_full;
    assign count_out     = level_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = udf_q;

`ifdef SPI_TXFIFO_THRESH_EN
    logic below_q, below_d;

    always_comb begin
        below_d = (level_q <= thresh_in);
    end

    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            below_q <= 1'b1;
        end else begin
            below_q <= below_d;
        end
    end

    assign below_thresh_out = below_q;
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo: queue-based reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_spi_tx_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          empty, full, ovf, udf;
    logic [CW-1:0] count;
`ifdef SPI_TXFIFO_THRESH_EN
    logic [CW-1:0] thresh = CW'(2);
    logic          below;
`endif

    spi_tx_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
        .apb_clk_in       (clk),
        .apb_rst_in       (rst),
        .flush_in         (flush),
        .wr_en_in         (wr_en),
        .wr_data_in       (wr_data),
        .rd_en_in         (rd_en),
        .rd_data_out      (rd_data),
        .empty_out        (empty),
        .full_out         (full),
        .count_out        (count),
        .overflow_out     (ovf),
        .underflow_out    (udf),
`ifdef SPI_TXFIFO_THRESH_EN
        .thresh_in        (thresh),
        .below_thresh_out (below),
`endif
        .err_clr_in       (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue, flags as bits.
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    bit         chk_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (int'(count) != m_q.size() || empty !== (m_q.size() == 0) ||
                full !== (m_q.size() == DEPTH) || ovf !== m_ovf || udf !== m_udf ||
                (m_q.size() != 0 && rd_data !== m_q[0])) begin
                miscompares++;
                $display("FAIL cycle t=%0t: dut cnt=%0d e=%b f=%b ovf=%b udf=%b head=%02h, model cnt=%0d ovf=%b udf=%b head=%02h",
                         $time, count, empty, full, ovf, udf, rd_data, m_q.size(), m_ovf, m_udf,
                         (m_q.size() != 0) ? m_q[0] : 8'h00);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive strobes, take the edge, advance the model, return at negedge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic clr, input logic rs);
        bit was_full, was_empty;
        wr_en = wr; wr_data = d; rd_en = rd; flush = fl; err_clr = clr; rst = rs;
        @(posedge clk);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (rs) begin
            m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        end else if (fl) begin
            m_q.delete();
        end else begin
            m_ovf = (m_ovf && !clr) || (wr && was_full && !rd);
            m_udf = (m_udf && !clr) || (rd && was_empty);
            if (rd && !was_empty) void'(m_q.pop_front());
            if (wr && (!was_full || rd)) m_q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic pop();                     step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic clr();                     step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); endtask

    logic [7:0] wrap_exp [8];

    initial begin
        wrap_exp = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hB1, 8'hB2, 8'hB3};

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_lit("reset_count", int'(count), 0);
        check_lit("reset_empty", int'(empty), 1);
        check_lit("reset_full",  int'(full), 0);
        check_lit("reset_flags", int'({ovf, udf}), 0);

        // Ordered fill and drain
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        check_lit("fill_full",  int'(full), 1);
        check_lit("fill_count", int'(count), 8);
        for (int i = 0; i < 8; i++) begin
            check_lit("drain_head", int'(rd_data), 'h11 + i);
            pop();
        end
        check_lit("drain_empty", int'(empty), 1);

        // Overflow, then wrap the pointers
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        push(8'hAA);
        check_lit("ovf_set",   int'(ovf), 1);
        check_lit("ovf_count", int'(count), 8);
        for (int i = 0; i < 3; i++) pop();
        for (int i = 0; i < 3; i++) push(8'hB1 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            check_lit("wrap_head", int'(rd_data), int'(wrap_exp[i]));
            pop();
        end
        clr();
        check_lit("ovf_clr", int'(ovf), 0);

        // Simultaneous push/pop while full
        for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("pp_full_count", int'(count), 8);
        check_lit("pp_full_ovf",   int'(ovf), 0);
        for (int i = 0; i < 7; i++) pop();
        check_lit("pp_full_last", int'(rd_data), 'hC0);
        pop();

        // Simultaneous push/pop while empty
        step(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("pp_empty_udf",   int'(udf), 1);
        check_lit("pp_empty_count", int'(count), 1);
        check_lit("pp_empty_head",  int'(rd_data), 'hD0);

        // Flush at level 5 with a coincident push; udf must survive
        for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
        check_lit("pre_flush_count", int'(count), 5);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
        check_lit("flush_count", int'(count), 0);
        check_lit("flush_udf",   int'(udf), 1);
        push(8'h61);
        check_lit("post_flush_head", int'(rd_data), 'h61);
        pop();

        // Clear coinciding with a new underflow leaves the flag set
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        check_lit("clr_vs_event", int'(udf), 1);
        clr();
        check_lit("udf_clr", int'(udf), 0);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) push(8'h71 + 8'(i));
        step(1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 1'b1);
        check_lit("midrst_empty", int'(empty), 1);
        push(8'h81);
        push(8'h82);
        check_lit("midrst_head", int'(rd_data), 'h81);
        pop();
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
